uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 34 +++
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if -- bundle of the UART receiver's line, frame configuration and
// result signals.
//   RX_IN      serial line, idle high (driven by master)
//   Prescale   oversampling ratio 8/16/32 (driven by master)
//   PAR_EN     frame carries a parity bit (driven by master)
//   PAR_TYP    0 = even, 1 = odd parity (driven by master)
//   P_DATA     last good data word (driven by slave)
//   data_valid one-cycle pulse, good frame in P_DATA (driven by slave)
//   par_err    one-cycle pulse, parity mismatch (driven by slave)
//   stp_err    one-cycle pulse, stop bit sampled 0 (driven by slave)
// ---------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int OP_WIDTH = 8
);
    logic                RX_IN;
    logic [5:0]          Prescale;
    logic                PAR_EN;
    logic                PAR_TYP;
    logic [OP_WIDTH-1:0] P_DATA;
    logic                data_valid;
    logic                par_err;
    logic                stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver (start, OP_WIDTH data bits LSB first,
// optional parity, one stop bit).
//   CLK   oversampling clock, all state on rising edge
//   RST   asynchronous active-low reset
//   bus   uart_rx_if.slave: RX_IN/Prescale/PAR_EN/PAR_TYP in,
//         P_DATA/data_valid/par_err/stp_err out
// Optional feature: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3
// vote of the samples at Prescale/2-1, Prescale/2, Prescale/2+1 (decision at
// Prescale/2+1). Without it the bit is the single sample at Prescale/2.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int OP_WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);
    localparam int BW = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state, state_nxt;
    logic                sync1, rx_s;
    logic [5:0]          cnt, cnt_nxt;
    logic [BW-1:0]       bit_cnt, bit_cnt_nxt;
    logic [5:0]          pre;
    logic                pen, ptyp;
    logic [OP_WIDTH-1:0] shift, p_data;
    logic                par_bad;
    logic                dv_r, pe_r, se_r;

    // Comb-to-datapath controls
    logic                latch_cfg, shift_en, par_chk;
    logic                dv_nxt, pe_nxt, se_nxt;

    logic [5:0]          half;
    logic                end_tick, dec_tick, bit_val;
    logic [5:0]          cnt_adv;

    assign half     = pre >> 1;
    // Wrap at Prescale-1; an illegal Prescale of 0 wraps at 63, so every bit
    // period stays bounded and the FSM always comes back to IDLE.
    assign end_tick = (cnt == pre - 6'd1);
    assign cnt_adv  = end_tick ? 6'd0 : cnt + 6'd1;

`ifdef UART_RX_MAJORITY_EN
    logic samp_a, samp_b;
    assign dec_tick = (cnt == half + 6'd1);
    assign bit_val  = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (cnt == half - 6'd1) samp_a <= rx_s;
            if (cnt == half)        samp_b <= rx_s;
        end
    end
`else
    assign dec_tick = (cnt == half);
    assign bit_val  = rx_s;
`endif

    // 2-flop synchronizer, reset to the idle level
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= bus.RX_IN;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt_adv;
        bit_cnt_nxt = bit_cnt;
        latch_cfg   = 1'b0;
        shift_en    = 1'b0;
        par_chk     = 1'b0;
        dv_nxt      = 1'b0;
        pe_nxt      = 1'b0;
        se_nxt      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                bit_cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = START;
                    latch_cfg = 1'b1;
                    // The detecting cycle is edge 0 of the start bit, so the
                    // cleared count has already advanced once on entry.
                    cnt_nxt   = (bus.Prescale == 6'd1) ? 6'd0 : 6'd1;
                end
            end
            START: begin
                if (dec_tick && bit_val) begin
                    state_nxt = IDLE;          // glitch, not a start bit
                    cnt_nxt   = '0;
                end else if (end_tick) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (dec_tick) shift_en = 1'b1;
                if (end_tick) begin
                    if (bit_cnt == BW'(OP_WIDTH - 1)) begin
                        state_nxt   = pen ? PARITY : STOP;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (dec_tick) par_chk = 1'b1;
                if (end_tick) state_nxt = STOP;
            end
            STOP: begin
                // end_tick exit only matters for illegal Prescale values
                // where the decision point lies beyond the wrap.
                if (dec_tick || end_tick) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    dv_nxt    = bit_val & ~par_bad;
                    pe_nxt    = par_bad;
                    se_nxt    = ~bit_val;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pre     <= '0;
            pen     <= 1'b0;
            ptyp    <= 1'b0;
            shift   <= '0;
            par_bad <= 1'b0;
            p_data  <= '0;
            dv_r    <= 1'b0;
            pe_r    <= 1'b0;
            se_r    <= 1'b0;
        end else begin
            if (latch_cfg) begin
                pre     <= bus.Prescale;
                pen     <= bus.PAR_EN;
                ptyp    <= bus.PAR_TYP;
                par_bad <= 1'b0;
            end
            if (shift_en) shift   <= {bit_val, shift[OP_WIDTH-1:1]};
            if (par_chk)  par_bad <= bit_val ^ (^shift) ^ ptyp;
            if (dv_nxt)   p_data  <= shift;
            dv_r <= dv_nxt;
            pe_r <= pe_nxt;
            se_r <= se_nxt;
        end
    end

    assign bus.P_DATA     = p_data;
    assign bus.data_valid = dv_r;
    assign bus.par_err    = pe_r;
    assign bus.stp_err    = se_r;
endmodule
